// File: rtl/game_pkg.sv
// Shared game-flow definitions: state codes, player-status codes and the
// level/world defaults also used by the Scrolls and Obstacles generators.
package game_pkg;

  typedef enum logic [2:0] {
    ST_START     = 3'd0,
    ST_PLAYING   = 3'd1,
    ST_LEVEL_UP  = 3'd2,
    ST_WORLD_UP  = 3'd3,
    ST_LIFE_LOST = 3'd4,
    ST_LOSE      = 3'd5,
    ST_WIN       = 3'd6
  } state_e;

  localparam logic [1:0] PS_PLAYING = 2'd0;
  localparam logic [1:0] PS_PASS    = 2'd1;
  localparam logic [1:0] PS_DIED    = 2'd2;

  localparam int LEVELS_PER_WORLD = 4;
  localparam int NUM_WORLDS       = 4;

endpackage

// File: rtl/game_flow_ctrl_banner_timer.sv
// Saturating frame counter that times how long a banner screen stays up.
module banner_timer
  import game_pkg::*;
#(
  parameter int BANNER_FRAMES = 120
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic frame_tick,
  output logic done
);

  localparam int CW = $clog2(BANNER_FRAMES + 1);
  localparam logic [CW-1:0] CMAX = CW'(BANNER_FRAMES);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q <= '0;
    end else if (frame_tick && (count_q != CMAX)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign done = (count_q == CMAX);

endmodule

// File: rtl/game_flow_ctrl.sv
// Game-flow sequencer: walks levels and worlds, tracks lives, freezes motion
// outside active play and pulses load_level on every entry into PLAYING.
module game_flow_ctrl #(
  parameter int LEVELS_PER_WORLD = game_pkg::LEVELS_PER_WORLD,
  parameter int NUM_WORLDS       = game_pkg::NUM_WORLDS,
  parameter int START_LIVES      = 3,
  parameter int MAX_LIVES        = 9,
  parameter int BANNER_FRAMES    = 120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic [1:0] player_status,
  input  logic       frame_tick,
  output logic [2:0] game_status,
  output logic [1:0] world,
  output logic [2:0] level,
  output logic [3:0] lives,
  output logic       freeze,
  output logic       load_level
);
  import game_pkg::*;

  localparam logic [2:0] LAST_LEVEL = 3'(LEVELS_PER_WORLD - 1);
  localparam logic [1:0] LAST_WORLD = 2'(NUM_WORLDS - 1);
  localparam logic [3:0] LIVES_INIT = 4'(START_LIVES);
  localparam logic [3:0] LIVES_MAX  = 4'(MAX_LIVES);

  state_e     state_q;
  logic [1:0] world_q;
  logic [2:0] level_q;
  logic [3:0] lives_q;
  logic       freeze_q;
  logic       load_q;
  logic       start_q;
  logic       tmr_clr_q;
  logic       banner_done;
  logic       start_rise;
  logic       pass;
  logic       died;

  assign start_rise = start_btn & ~start_q;
  assign pass       = (player_status == PS_PASS);
  assign died       = (player_status == PS_DIED);

  banner_timer #(.BANNER_FRAMES(BANNER_FRAMES)) u_banner_timer (
    .clk        (clk),
    .rst        (rst),
    .clear      (tmr_clr_q),
    .frame_tick (frame_tick),
    .done       (banner_done)
  );

  always_ff @(posedge clk) begin
    // Tracks the button even in reset so a press held through reset is not a rise.
    start_q <= start_btn;
    if (rst) begin
      state_q   <= ST_START;
      world_q   <= '0;
      level_q   <= '0;
      lives_q   <= LIVES_INIT;
      freeze_q  <= 1'b1;
      load_q    <= 1'b0;
      tmr_clr_q <= 1'b1;
    end else begin
      load_q    <= 1'b0;
      tmr_clr_q <= 1'b1;
      case (state_q)
        ST_START: begin
          if (start_rise) begin
            state_q  <= ST_PLAYING;
            world_q  <= '0;
            level_q  <= '0;
            lives_q  <= LIVES_INIT;
            freeze_q <= 1'b0;
            load_q   <= 1'b1;
          end
        end
        ST_PLAYING: begin
          if (pass) begin
            freeze_q <= 1'b1;
            if (level_q < LAST_LEVEL) begin
              state_q <= ST_LEVEL_UP;
              level_q <= level_q + 1'b1;
            end else if (world_q < LAST_WORLD) begin
              state_q <= ST_WORLD_UP;
              world_q <= world_q + 1'b1;
              level_q <= '0;
              if (lives_q < LIVES_MAX) lives_q <= lives_q + 1'b1;
            end else begin
              state_q <= ST_WIN;
            end
          end else if (died) begin
            freeze_q <= 1'b1;
            if (lives_q <= 4'd1) begin
              state_q <= ST_LOSE;
              lives_q <= '0;
            end else begin
              state_q <= ST_LIFE_LOST;
              lives_q <= lives_q - 1'b1;
            end
          end
        end
        ST_LEVEL_UP, ST_WORLD_UP, ST_LIFE_LOST: begin
          // Reserved status code 3 counts as "playing", so it also releases the banner.
          if (banner_done && !pass && !died) begin
            state_q  <= ST_PLAYING;
            freeze_q <= 1'b0;
            load_q   <= 1'b1;
          end else begin
            tmr_clr_q <= 1'b0;
          end
        end
        ST_LOSE, ST_WIN: begin
          if (banner_done && start_rise) begin
            state_q  <= ST_PLAYING;
            world_q  <= '0;
            level_q  <= '0;
            lives_q  <= LIVES_INIT;
            freeze_q <= 1'b0;
            load_q   <= 1'b1;
          end else begin
            tmr_clr_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= ST_START;
          world_q  <= '0;
          level_q  <= '0;
          lives_q  <= LIVES_INIT;
          freeze_q <= 1'b1;
        end
      endcase
    end
  end

  assign game_status = state_q;
  assign world       = world_q;
  assign level       = level_q;
  assign lives       = lives_q;
  assign freeze      = freeze_q;
  assign load_level  = load_q;

endmodule
